// File: rtl/playback_worker_pkg.sv
// Shared definitions for the stream workers: FSM encoding and default counter width.
package playback_worker_pkg;

  localparam int unsigned PW_LEN_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAD   = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } pw_state_t;

endpackage

// File: rtl/playback_worker_skid.sv
// Two-entry registered AXI4-Stream slice; output driven straight from the head register.
module axis_skid_buffer #(
  parameter int unsigned P_WIDTH = 37
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [P_WIDTH-1:0] s_data,
  output logic               s_ready,
  output logic               m_valid,
  output logic [P_WIDTH-1:0] m_data,
  input  logic               m_ready
);

  logic [P_WIDTH-1:0] head;
  logic [P_WIDTH-1:0] tail;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign m_data  = head;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= s_data;
          else               tail <= s_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // simultaneous push/pop keeps occupancy; new beat lands behind whatever remains
          if (count == 2'd1) begin
            head <= s_data;
          end else begin
            head <= tail;
            tail <= s_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/playback_worker.sv
// Playback stream worker: one framed AXI4-Stream burst (optional zero pad + payload) per length command.
module playback_worker
  import playback_worker_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_LEN_WIDTH          = PW_LEN_WIDTH
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic [C_LEN_WIDTH-1:0]            stream_len,
  input  logic [C_LEN_WIDTH-1:0]            pad_length,
  input  logic                              len_valid,
  output logic                              len_ready,
  output logic                              done,
  output logic [C_LEN_WIDTH-1:0]            underrun_count,
  input  logic                              underrun_clear
);

  localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned PW = DW + SW + 1;
  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};

  pw_state_t              state;
  pw_state_t              state_next;
  logic [C_LEN_WIDTH-1:0] len_cnt;
  logic [C_LEN_WIDTH-1:0] pad_cnt;

  logic          push_valid;
  logic          push_last;
  logic [DW-1:0] push_tdata;
  logic [SW-1:0] push_tstrb;
  logic          push_fire;
  logic          skid_ready;
  logic [PW-1:0] skid_out;
  logic          cmd_fire;
  logic          tlast_fire;
  logic          unused_tlast;

  assign unused_tlast = S_AXIS_TLAST;
  assign len_ready    = (state == ST_IDLE);
  assign cmd_fire     = len_valid && len_ready;
  assign push_fire    = push_valid && skid_ready;
  assign tlast_fire   = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= ST_IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (pad_length != '0)      state_next = ST_PAD;
          else if (stream_len != '0) state_next = ST_PLAY;
        end
      end
      ST_PAD: begin
        if (push_fire && pad_cnt == LEN_ONE)
          state_next = (len_cnt != '0) ? ST_PLAY : ST_DRAIN;
      end
      ST_PLAY: begin
        if (push_fire && len_cnt == LEN_ONE) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tlast_fire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // TLAST marks the final pushed beat of pad+payload; upstream framing is never consulted
  always_comb begin
    push_valid    = 1'b0;
    push_last     = 1'b0;
    push_tdata    = '0;
    push_tstrb    = '0;
    S_AXIS_TREADY = 1'b0;
    unique case (state)
      ST_PAD: begin
        push_valid = 1'b1;
        push_tstrb = '1;
        push_last  = (pad_cnt == LEN_ONE) && (len_cnt == '0);
      end
      ST_PLAY: begin
        S_AXIS_TREADY = skid_ready;
        push_valid    = S_AXIS_TVALID;
        push_tdata    = S_AXIS_TDATA;
        push_tstrb    = S_AXIS_TSTRB;
        push_last     = (len_cnt == LEN_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      len_cnt <= '0;
      pad_cnt <= '0;
    end else if (cmd_fire) begin
      len_cnt <= stream_len;
      pad_cnt <= pad_length;
    end else begin
      if (state == ST_PAD && push_fire && pad_cnt != '0)  pad_cnt <= pad_cnt - LEN_ONE;
      if (state == ST_PLAY && push_fire && len_cnt != '0) len_cnt <= len_cnt - LEN_ONE;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      done <= 1'b0;
    end else begin
      done <= (cmd_fire && stream_len == '0 && pad_length == '0) ||
              (state == ST_DRAIN && tlast_fire);
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      underrun_count <= '0;
    end else if (underrun_clear) begin
      underrun_count <= '0;
    end else if (state == ST_PLAY && !S_AXIS_TVALID && skid_ready && underrun_count != '1) begin
      underrun_count <= underrun_count + LEN_ONE;
    end
  end

  axis_skid_buffer #(
    .P_WIDTH(PW)
  ) u_skid (
    .clk     (S_AXIS_ACLK),
    .rst_n   (S_AXIS_ARESETN),
    .s_valid (push_valid),
    .s_data  ({push_last, push_tstrb, push_tdata}),
    .s_ready (skid_ready),
    .m_valid (M_AXIS_TVALID),
    .m_data  (skid_out),
    .m_ready (M_AXIS_TREADY)
  );

  assign M_AXIS_TDATA = skid_out[DW-1:0];
  assign M_AXIS_TSTRB = skid_out[DW+SW-1:DW];
  assign M_AXIS_TLAST = skid_out[PW-1];

endmodule

// File: doc/playback_worker.md
Name: playback_worker

Overview:
- Transmit-side counterpart of the capture stream worker: takes a sample stream from memory (DMA read) and emits exactly one framed AXI4-Stream burst per length command toward the DAC path.
- Optionally inserts a run of zero samples ahead of the payload. The capture side skips samples; playback pads them.
- Owns framing: TLAST is regenerated internally and upstream TLAST is ignored.
- Output is fully registered through a 2-entry skid buffer.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, input sample width.
- C_M_AXIS_TDATA_WIDTH, 32, output sample width; must equal C_S_AXIS_TDATA_WIDTH.
- C_LEN_WIDTH, 32, width of length, pad and underrun counters.

Ports:
- S_AXIS_ACLK  in  1  sole clock.
- S_AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  source samples.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifier; forwarded.
- S_AXIS_TLAST  in  1  ignored.
- S_AXIS_TVALID  in  1  source valid.
- S_AXIS_TREADY  out  1  accept source sample.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  output samples.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  output byte qualifier.
- M_AXIS_TLAST  out  1  last beat of burst.
- M_AXIS_TREADY  in  1  sink ready.
- stream_len  in  C_LEN_WIDTH  payload samples per burst.
- pad_length  in  C_LEN_WIDTH  zero samples before payload.
- len_valid  in  1  command valid.
- len_ready  out  1  command accepted when high with len_valid.
- done  out  1  one-cycle pulse at burst completion.
- underrun_count  out  C_LEN_WIDTH  saturating starvation counter.
- underrun_clear  in  1  synchronous clear of underrun_count.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM to IDLE, skid buffer emptied, counters to 0.
  - Outputs: M_AXIS_TVALID/TDATA/TSTRB/TLAST = 0, S_AXIS_TREADY = 0, done = 0, underrun_count = 0.
  - Reset mid-burst discards all in-flight beats; no TLAST is emitted.
- States: IDLE, PAD, PLAY, DRAIN.
- len_ready = 1 only in IDLE, high in the first cycle after reset release.
- IDLE, on len_valid && len_ready:
  - Latch stream_len into len_cnt and pad_length into pad_cnt.
  - pad_length > 0 -> PAD.
  - Else stream_len > 0 -> PLAY.
  - Both 0 -> stay IDLE; done pulses the next cycle; no beats are emitted.
- PAD:
  - Each cycle the skid buffer has room, push one beat: TDATA = 0, TSTRB = all ones; pad_cnt decrements.
  - S_AXIS_TREADY = 0.
  - Leaving the final pad beat: len_cnt > 0 -> PLAY, else -> DRAIN.
- PLAY:
  - S_AXIS_TREADY = skid not full.
  - Each source handshake pushes {TDATA, TSTRB} and decrements len_cnt.
  - At len_cnt == 1 handshake -> DRAIN.
  - Source samples beyond stream_len are never accepted.
- TLAST is set on the pushed beat that is the final beat of pad+payload (last pad beat when stream_len == 0). Exactly one TLAST per burst.
- DRAIN:
  - S_AXIS_TREADY = 0.
  - Wait for the TLAST beat's output handshake (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST).
  - done is registered high the next cycle, with state = IDLE in that same cycle.
- Latency: input/pad push to M_AXIS_TVALID is 1 cycle.
- Throughput: 1 beat/cycle under continuous TREADY. The skid buffer absorbs a TREADY drop with no bubble or loss.
- Output holds stable while TVALID && !TREADY, per AXI4-Stream.
- Underrun counting:
  - Increments each PLAY cycle with S_AXIS_TVALID = 0 and skid not full.
  - Saturates at all ones.
  - underrun_clear has priority over increment in the same cycle.
- Counter arithmetic is unsigned C_LEN_WIDTH. Zero-length fields are legal; no wrap occurs since decrement happens only when the count is non-zero.

Decomposition:
- Shared package: FSM state encoding (IDLE/PAD/PLAY/DRAIN, 2 bits) and the default length width constant, reused by the capture side.
- One sub-module: axis_skid_buffer, 2-entry registered slice parameterised on payload width (data+strb+last).

Test Plan:
- stream_len=8, pad=0, TREADY held 1, source always valid -> 8 beats matching input, TLAST on beat 8 only, done 1 cycle after beat 8, len_ready back to 1.
- stream_len=4, pad=3 -> 3 beats of 0 then 4 source beats, TLAST on beat 7, S_AXIS_TREADY low during the pad beats.
- stream_len=16, M_AXIS_TREADY toggling 1010..., source inserting random bubbles -> output sequence equals input with no loss or duplication. underrun_count equals bubble cycles with skid not full; underrun_clear returns it to 0.
- stream_len=0, pad=0 -> no beats, done pulse next cycle. stream_len=0, pad=2 -> two zero beats, TLAST on the second.
- Assert reset mid-PLAY after 5 of 10 beats -> all outputs 0 immediately, no TLAST. A new command of stream_len=3 afterward completes normally.
- len_valid held high while busy -> ignored until IDLE. Source upstream TLAST asserted at beat 2 of 6 -> output TLAST only on beat 6.
